// File: rtl/punc_mem_pkg.sv
// Shared types and constants for the PUnC memory responder.
// Optional statistics counters are enabled with PUNC_MEM_STATS_EN.
package punc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned ADDR_W     = 16;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

    // Full-width compare: any bit above the implemented depth makes the address out of range.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth_log2);
        return (depth_log2 >= ADDR_W) || ((addr >> depth_log2) == '0);
    endfunction

endpackage

// File: rtl/punc_mem_array.sv
// Synchronous single-port word array with registered read; contents are never reset.
module punc_mem_array #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/punc_mem_responder.sv
// Handshake memory responder with programmable wait states for the PUnC core.
// Define PUNC_MEM_STATS_EN to add saturating read/write/error access counters.
module punc_mem_responder
    import punc_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef PUNC_MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [15:0]       err_count
`endif
);

    state_t                  state;
    state_t                  state_next;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    in_range;
    logic                    access;
    logic                    arr_we;
    logic [DATA_W-1:0]       arr_rdata;

    assign in_range = addr_in_range(addr_q, DEPTH_LOG2);
    assign access   = (state == BUSY) && (wait_cnt == '0);
    assign arr_we   = access && in_range && (we_q == REQ_WR);

    // The array keeps re-reading the latched address, so its output holds steady through RESP.
    punc_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (addr_q[DEPTH_LOG2-1:0]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_valid) state_next = BUSY;
            BUSY:    if (wait_cnt == '0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_err   = (state == RESP) && !in_range;
        rsp_rdata = ((state == RESP) && in_range && (we_q == REQ_RD)) ? arr_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            we_q     <= REQ_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if ((state == IDLE) && req_valid) begin
            wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
            we_q     <= req_we;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end else if ((state == BUSY) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
        end
    end

`ifdef PUNC_MEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else if (access) begin
            if (!in_range) begin
                if (err_count != '1) err_count <= err_count + 16'd1;
            end else if (we_q == REQ_WR) begin
                if (wr_count != '1) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != '1) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_punc_mem_responder.sv
// Directed self-checking bench for punc_mem_responder (WAIT_STATES 2 and 0 instances).
// Statistics checks run only when PUNC_MEM_STATS_EN is defined.
module tb_punc_mem_responder;

    localparam int Z = 0;  // WAIT_STATES = 0 instance
    localparam int M = 1;  // WAIT_STATES = 2 instance

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_err   [2];
`ifdef PUNC_MEM_STATS_EN
    logic [15:0] rd_count  [2];
    logic [15:0] wr_count  [2];
    logic [15:0] err_count [2];
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    punc_mem_responder #(
        .DATA_W      (16),
        .DEPTH_LOG2  (8),
        .WAIT_STATES (0)
    ) u_dut_ws0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[Z]),
        .req_ready (req_ready[Z]),
        .req_we    (req_we[Z]),
        .req_addr  (req_addr[Z]),
        .req_wdata (req_wdata[Z]),
        .rsp_valid (rsp_valid[Z]),
        .rsp_ready (rsp_ready[Z]),
        .rsp_rdata (rsp_rdata[Z]),
        .rsp_err   (rsp_err[Z])
`ifdef PUNC_MEM_STATS_EN
        ,
        .rd_count  (rd_count[Z]),
        .wr_count  (wr_count[Z]),
        .err_count (err_count[Z])
`endif
    );

    punc_mem_responder #(
        .DATA_W      (16),
        .DEPTH_LOG2  (8),
        .WAIT_STATES (2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[M]),
        .req_ready (req_ready[M]),
        .req_we    (req_we[M]),
        .req_addr  (req_addr[M]),
        .req_wdata (req_wdata[M]),
        .rsp_valid (rsp_valid[M]),
        .rsp_ready (rsp_ready[M]),
        .rsp_rdata (rsp_rdata[M]),
        .rsp_err   (rsp_err[M])
`ifdef PUNC_MEM_STATS_EN
        ,
        .rd_count  (rd_count[M]),
        .wr_count  (wr_count[M]),
        .err_count (err_count[M])
`endif
    );

    // Present a request, let it be accepted, then count edges until rsp_valid (bounded).
    task automatic send(input int d, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat);
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = 16'hFFFF;
        req_wdata[d] = 16'hDEAD;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rsp_valid[d] && lat < 50);
    endtask

    task automatic consume(input int d);
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req_ready[M] !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready[M]); end
        checks++; if (rsp_valid[M] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid[M]); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rsp_rdata[M] !== 16'h0000) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0000", rsp_rdata[M]); end
        checks++; if (rsp_err[M] !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err[M]); end
        checks++; if (req_ready[Z] !== 1'b1) begin failures++; $display("FAIL reset_ws0_req_ready got=%b exp=1", req_ready[Z]); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int lat;
        send(M, 1'b1, 16'h0005, 16'hBEEF, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
        checks++; if (rsp_rdata[M] !== 16'h0000) begin failures++; $display("FAIL wr_rdata got=%h exp=0000", rsp_rdata[M]); end
        checks++; if (rsp_err[M] !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", rsp_err[M]); end
        consume(M);
        send(M, 1'b0, 16'h0005, 16'h0000, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        checks++; if (rsp_rdata[M] !== 16'hBEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=beef", rsp_rdata[M]); end
        checks++; if (rsp_err[M] !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", rsp_err[M]); end
        consume(M);
    endtask

    task automatic test_backpressure();
        int lat;
        send(M, 1'b1, 16'h0020, 16'h0020, lat);
        consume(M);
        send(M, 1'b0, 16'h0020, 16'h0000, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        // A write presented during RESP must be ignored.
        req_we[M]    = 1'b1;
        req_addr[M]  = 16'h0020;
        req_wdata[M] = 16'hFFFF;
        req_valid[M] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_valid[M] !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, rsp_valid[M]); end
            checks++; if (rsp_rdata[M] !== 16'h0020) begin failures++; $display("FAIL bp_rdata[%0d] got=%h exp=0020", i, rsp_rdata[M]); end
            checks++; if (req_ready[M] !== 1'b0) begin failures++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, req_ready[M]); end
            @(posedge clk); #1;
        end
        rsp_ready[M] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[M] = 1'b0;
        req_valid[M] = 1'b0;
        checks++; if (rsp_valid[M] !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", rsp_valid[M]); end
        checks++; if (req_ready[M] !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", req_ready[M]); end
        checks++; if (rsp_rdata[M] !== 16'h0000) begin failures++; $display("FAIL bp_release_rdata got=%h exp=0000", rsp_rdata[M]); end
        send(M, 1'b0, 16'h0020, 16'h0000, lat);
        checks++; if (rsp_rdata[M] !== 16'h0020) begin failures++; $display("FAIL bp_ignored_write got=%h exp=0020", rsp_rdata[M]); end
        consume(M);
    endtask

    task automatic test_out_of_range();
        int lat;
        send(M, 1'b1, 16'h0000, 16'h0A0A, lat);
        consume(M);
        send(M, 1'b0, 16'h0100, 16'h0000, lat);
        checks++; if (rsp_err[M] !== 1'b1) begin failures++; $display("FAIL oor_rd_err got=%b exp=1", rsp_err[M]); end
        checks++; if (rsp_rdata[M] !== 16'h0000) begin failures++; $display("FAIL oor_rd_rdata got=%h exp=0000", rsp_rdata[M]); end
        consume(M);
        checks++; if (rsp_err[M] !== 1'b0) begin failures++; $display("FAIL oor_err_clear got=%b exp=0", rsp_err[M]); end
        send(M, 1'b1, 16'h0100, 16'h1234, lat);
        checks++; if (rsp_err[M] !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%b exp=1", rsp_err[M]); end
        consume(M);
        send(M, 1'b0, 16'h0000, 16'h0000, lat);
        checks++; if (rsp_rdata[M] !== 16'h0A0A) begin failures++; $display("FAIL oor_addr0_intact got=%h exp=0a0a", rsp_rdata[M]); end
        checks++; if (rsp_err[M] !== 1'b0) begin failures++; $display("FAIL oor_addr0_err got=%b exp=0", rsp_err[M]); end
        consume(M);
        send(M, 1'b0, 16'h1005, 16'h0000, lat);
        checks++; if (rsp_err[M] !== 1'b1) begin failures++; $display("FAIL oor_high_bits_err got=%b exp=1", rsp_err[M]); end
        checks++; if (rsp_rdata[M] !== 16'h0000) begin failures++; $display("FAIL oor_high_bits_rdata got=%h exp=0000", rsp_rdata[M]); end
        consume(M);
        send(M, 1'b1, 16'h00FF, 16'h7777, lat);
        consume(M);
        send(M, 1'b0, 16'h00FF, 16'h0000, lat);
        checks++; if (rsp_rdata[M] !== 16'h7777) begin failures++; $display("FAIL top_addr_rdata got=%h exp=7777", rsp_rdata[M]); end
        checks++; if (rsp_err[M] !== 1'b0) begin failures++; $display("FAIL top_addr_err got=%b exp=0", rsp_err[M]); end
        consume(M);
    endtask

    task automatic test_wait0();
        int lat;
        send(Z, 1'b1, 16'h0003, 16'h4242, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL ws0_wr_latency got=%0d exp=1", lat); end
        consume(Z);
        send(Z, 1'b0, 16'h0003, 16'h0000, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL ws0_rd_latency got=%0d exp=1", lat); end
        checks++; if (rsp_rdata[Z] !== 16'h4242) begin failures++; $display("FAIL ws0_rdata got=%h exp=4242", rsp_rdata[Z]); end
        consume(Z);
    endtask

    task automatic test_reset_mid_write();
        int lat;
        send(M, 1'b1, 16'h0007, 16'h5A5A, lat);
        consume(M);
        req_we[M]    = 1'b1;
        req_addr[M]  = 16'h0007;
        req_wdata[M] = 16'hAAAA;
        req_valid[M] = 1'b1;
        @(posedge clk); #1;
        req_valid[M] = 1'b0;
        checks++; if (req_ready[M] !== 1'b0) begin failures++; $display("FAIL mid_busy_ready got=%b exp=0", req_ready[M]); end
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready[M] !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", req_ready[M]); end
        checks++; if (rsp_valid[M] !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", rsp_valid[M]); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid[M] !== 1'b0 || rsp_rdata[M] !== 16'h0000 || rsp_err[M] !== 1'b0) begin
                failures++;
                $display("FAIL mid_rst_outputs[%0d] got=%b/%h/%b exp=0/0000/0", i, rsp_valid[M], rsp_rdata[M], rsp_err[M]);
            end
        end
        rst_n = 1'b1;
        send(M, 1'b0, 16'h0007, 16'h0000, lat);
        checks++; if (rsp_rdata[M] !== 16'h5A5A) begin failures++; $display("FAIL mid_rst_prior_value got=%h exp=5a5a", rsp_rdata[M]); end
        consume(M);
    endtask

`ifdef PUNC_MEM_STATS_EN
    task automatic test_stats();
        int lat;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (rd_count[M] !== 16'd0 || wr_count[M] !== 16'd0 || err_count[M] !== 16'd0) begin
            failures++;
            $display("FAIL stats_reset got=%0d/%0d/%0d exp=0/0/0", rd_count[M], wr_count[M], err_count[M]);
        end
        send(M, 1'b0, 16'h0005, 16'h0000, lat); consume(M);
        send(M, 1'b1, 16'h0010, 16'h1111, lat); consume(M);
        send(M, 1'b0, 16'h0007, 16'h0000, lat); consume(M);
        send(M, 1'b0, 16'h0200, 16'h0000, lat); consume(M);
        send(M, 1'b1, 16'h0011, 16'h2222, lat); consume(M);
        send(M, 1'b0, 16'h0000, 16'h0000, lat); consume(M);
        checks++; if (rd_count[M] !== 16'd3) begin failures++; $display("FAIL stats_rd got=%0d exp=3", rd_count[M]); end
        checks++; if (wr_count[M] !== 16'd2) begin failures++; $display("FAIL stats_wr got=%0d exp=2", wr_count[M]); end
        checks++; if (err_count[M] !== 16'd1) begin failures++; $display("FAIL stats_err got=%0d exp=1", err_count[M]); end
    endtask
`endif

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 16'h0000;
            req_wdata[d] = 16'h0000;
            rsp_ready[d] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_backpressure();
        test_out_of_range();
        test_wait0();
        test_reset_mid_write();
`ifdef PUNC_MEM_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
